result_collector: RTL and testbench

- Receive end of the matrix unit's serialized result stream.
- The compute controller reads each result word from the result memory and emits it as CHUNKS narrow chunks, least-significant chunk first.
- This block reassembles the chunks into full words and stores ELEMS words in a local result buffer, indexed in row-major order. Each completed word is also announced with a one-cycle strobe.
- The buffer is then readable by the host over a synchronous read port.

---
 rtl/result_collector.sv | 125 ++++++++++++
 tb/tb_result_collector.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/result_collector.sv
// rtl/result_collector.sv - reassembles chunked result stream into a host-readable word buffer
module result_collector #(
  parameter int CHUNK_W = 8,
  parameter int CHUNKS  = 3,
  parameter int ELEMS   = 9,
  parameter int IDX_W   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        clear,
  input  logic                        in_valid,
  input  logic [CHUNK_W-1:0]          in_data,
  output logic                        in_ready,
  output logic                        word_strobe,
  output logic [CHUNK_W*CHUNKS-1:0]   word_data,
  output logic [IDX_W-1:0]            word_idx,
  input  logic                        rd_en,
  input  logic [IDX_W-1:0]            rd_addr,
  output logic [CHUNK_W*CHUNKS-1:0]   rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
);

  localparam int WORD_W = CHUNK_W * CHUNKS;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [IDX_W-1:0] LAST_ELEM  = IDX_W'(ELEMS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    chunk_cnt;
  logic [IDX_W-1:0]    elem_cnt;
  logic [WORD_W-1:0]   asm_reg;
  logic [WORD_W-1:0]   full_word;
  logic [WORD_W-1:0]   mem [ELEMS];
  logic                accept;
  logic                word_done;

  assign in_ready  = (state == COLLECT);
  assign busy      = (state == COLLECT);
  assign done      = (state == DONE);
  assign accept    = in_ready && in_valid && !clear;
  assign word_done = accept && (chunk_cnt == LAST_CHUNK);

  // The final chunk goes straight into the word so the buffer write happens on its own edge.
  always_comb begin
    full_word = asm_reg;
    full_word[(CHUNKS-1)*CHUNK_W +: CHUNK_W] = in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      chunk_cnt   <= '0;
      elem_cnt    <= '0;
      asm_reg     <= '0;
      word_strobe <= 1'b0;
      word_data   <= '0;
      word_idx    <= '0;
      overflow    <= 1'b0;
    end else begin
      word_strobe <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        chunk_cnt <= '0;
        elem_cnt  <= '0;
        asm_reg   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= COLLECT;
              chunk_cnt <= '0;
              elem_cnt  <= '0;
              asm_reg   <= '0;
            end
          end
          COLLECT: begin
            if (word_done) begin
              word_data   <= full_word;
              word_idx    <= elem_cnt;
              word_strobe <= 1'b1;
              chunk_cnt   <= '0;
              asm_reg     <= '0;
              elem_cnt    <= elem_cnt + IDX_W'(1);
              if (elem_cnt == LAST_ELEM) state <= DONE;
            end else if (accept) begin
              asm_reg[int'(chunk_cnt)*CHUNK_W +: CHUNK_W] <= in_data;
              chunk_cnt <= chunk_cnt + CNT_W'(1);
            end
          end
          DONE: begin
            if (start) begin
              state     <= COLLECT;
              chunk_cnt <= '0;
              elem_cnt  <= '0;
              asm_reg   <= '0;
              overflow  <= 1'b0;
            end else if (in_valid) begin
              overflow <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Buffer contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (word_done) mem[elem_cnt] <= full_word;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (rd_addr <= LAST_ELEM) ? mem[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - directed self-checking bench for result_collector
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        word_strobe;
  logic [23:0] word_data;
  logic [3:0]  word_idx;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic [23:0] rd_data;
  logic        busy;
  logic        done;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  int strobe_cnt = 0;
  logic [23:0] cap [16];

  result_collector dut (
    .clk(clk), .rst(rst), .start(start), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .word_strobe(word_strobe), .word_data(word_data), .word_idx(word_idx),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (word_strobe === 1'b1) begin
      cap[word_idx] = word_data;
      strobe_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input int base, input int i);
    logic [7:0] b0, b1, b2;
    b0 = 8'(base + 3*i);
    b1 = 8'(base + 3*i + 1);
    b2 = 8'(base + 3*i + 2);
    return {b2, b1, b0};
  endfunction

  task automatic read_chk(input string tag, input logic [3:0] addr, input logic [23:0] exp);
    rd_en = 1'b1;
    rd_addr = addr;
    tick();
    rd_en = 1'b0;
    chk(tag, {8'h0, rd_data}, {8'h0, exp});
  endtask

  task automatic send_chunks(input int base, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data = 8'(base + k);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_data = 8'h0; rd_en = 1'b0; rd_addr = 4'h0;
    tick(); tick();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_overflow", {31'h0, overflow}, 32'h0);
    chk("rst_strobe", {31'h0, word_strobe}, 32'h0);
    chk("rst_word_data", {8'h0, word_data}, 32'h0);
    chk("rst_word_idx", {28'h0, word_idx}, 32'h0);
    chk("rst_rd_data", {8'h0, rd_data}, 32'h0);
    rst = 1'b1;
    tick();

    // Basic back-to-back fill
    start = 1'b1; tick(); start = 1'b0;
    chk("fill_busy", {31'h0, busy}, 32'h1);
    chk("fill_in_ready", {31'h0, in_ready}, 32'h1);
    strobe_cnt = 0;
    send_chunks(1, 27);
    chk("fill_done", {31'h0, done}, 32'h1);
    chk("fill_busy_low", {31'h0, busy}, 32'h0);
    chk("fill_last_idx", {28'h0, word_idx}, 32'h8);
    tick();
    chk("fill_strobes", strobe_cnt, 9);
    chk("fill_word0", {8'h0, cap[0]}, 32'h030201);
    chk("fill_word8", {8'h0, cap[8]}, 32'h1B1A19);
    read_chk("fill_rd4", 4'd4, 24'h0F0E0D);
    for (int i = 0; i < 9; i++) read_chk($sformatf("fill_rd%0d", i), 4'(i), exp_word(1, i));

    // Overflow while DONE
    in_valid = 1'b1; in_data = 8'hFF;
    chk("ovf_in_ready", {31'h0, in_ready}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
    chk("ovf_in_ready2", {31'h0, in_ready}, 32'h0);
    read_chk("ovf_rd8", 4'd8, 24'h1B1A19);
    start = 1'b1; tick(); start = 1'b0;
    chk("ovf_cleared", {31'h0, overflow}, 32'h0);
    chk("ovf_restart_busy", {31'h0, busy}, 32'h1);

    // Gapped stream
    strobe_cnt = 0;
    for (int k = 0; k < 27; k++) begin
      in_valid = 1'b1; in_data = 8'(1 + k);
      tick();
      in_valid = 1'b0; in_data = 8'hAA;
      chk($sformatf("gap_strobe%0d", k), {31'h0, word_strobe}, {31'h0, (k % 3) == 2});
      tick(); tick();
    end
    chk("gap_strobes", strobe_cnt, 9);
    chk("gap_done", {31'h0, done}, 32'h1);
    for (int i = 0; i < 9; i++) read_chk($sformatf("gap_rd%0d", i), 4'(i), exp_word(1, i));

    // Clear mid-word drops the concurrent chunk
    start = 1'b1; tick(); start = 1'b0;
    send_chunks(8'h31, 4);
    in_valid = 1'b1; in_data = 8'h35; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_busy", {31'h0, busy}, 32'h0);
    chk("clr_in_ready", {31'h0, in_ready}, 32'h0);
    chk("clr_done", {31'h0, done}, 32'h0);
    tick();
    chk("clr_no_strobe", {31'h0, word_strobe}, 32'h0);

    // Fresh stream with ignored start and a same-cycle read/write of addr 2
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 27; k++) begin
      in_valid = 1'b1; in_data = 8'(8'h41 + k);
      start = (k == 1);
      rd_en = (k == 8);
      rd_addr = 4'd2;
      tick();
      if (k == 8) chk("rw_same_cycle_old", {8'h0, rd_data}, 32'h090807);
    end
    in_valid = 1'b0; start = 1'b0; rd_en = 1'b0;
    chk("fresh_done", {31'h0, done}, 32'h1);
    for (int i = 0; i < 9; i++) read_chk($sformatf("fresh_rd%0d", i), 4'(i), exp_word(8'h41, i));
    read_chk("rd_out_of_range", 4'd12, 24'h0);

    // Reset mid-collection
    start = 1'b1; tick(); start = 1'b0;
    send_chunks(1, 10);
    rd_en = 1'b1; rd_addr = 4'd5; tick(); rd_en = 1'b0;
    rst = 1'b0; tick(); rst = 1'b1;
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("mrst_done", {31'h0, done}, 32'h0);
    chk("mrst_overflow", {31'h0, overflow}, 32'h0);
    chk("mrst_word_data", {8'h0, word_data}, 32'h0);
    chk("mrst_word_idx", {28'h0, word_idx}, 32'h0);
    chk("mrst_rd_data", {8'h0, rd_data}, 32'h0);
    in_valid = 1'b1; in_data = 8'h77;
    tick(); tick();
    chk("mrst_idle_ready", {31'h0, in_ready}, 32'h0);
    chk("mrst_idle_busy", {31'h0, busy}, 32'h0);
    in_valid = 1'b0;
    read_chk("mrst_rd0", 4'd0, 24'h030201);
    read_chk("mrst_rd1", 4'd1, 24'h060504);
    read_chk("mrst_rd3", 4'd3, exp_word(8'h41, 3));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
